// File: rtl/game_pkg.sv
// Shared game types and motion constants used by the duck controller and its helpers.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPAWN  = 3'd1,
    FLY    = 3'd2,
    HIT    = 3'd3,
    FALL   = 3'd4,
    ESCAPE = 3'd5,
    NEXT   = 3'd6,
    DONE   = 3'd7
  } duck_state_t;

  localparam int VEL_BASE    = 1;
  localparam int FALL_STEP   = 4;
  localparam int ESCAPE_STEP = 4;
  localparam logic [1:0] SHOTS_INIT = 2'd3;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector for level inputs such as mouse buttons.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      level_p0 <= 1'b0;
      rise     <= 1'b0;
    end else begin
      level_p0 <= level;
      rise     <= level & ~level_p0;
    end
  end

endmodule

// File: rtl/duck_ctrl.sv
// Duck-hunt round controller: spawns a duck, moves it per frame, scores shots and
// sequences hit/fall/escape through a fixed number of rounds.
module duck_ctrl
  import game_pkg::*;
#(
  parameter int X_MIN         = 64,
  parameter int X_MAX         = 736,
  parameter int Y_MIN         = 32,
  parameter int Y_SPAWN       = 420,
  parameter int DUCK_W        = 64,
  parameter int DUCK_H        = 64,
  parameter int ROUNDS        = 10,
  parameter int FLIGHT_FRAMES = 300,
  parameter int HIT_FRAMES    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        frame_tick,
  input  logic [15:0] random,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        left_mouse,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_visible,
  output duck_state_t duck_state,
  output logic [7:0]  hits,
  output logic [1:0]  shots_left,
  output logic [3:0]  round_no,
  output logic        game_finished
);

  localparam int FC_W = $clog2(FLIGHT_FRAMES + 1);
  localparam logic [12:0] DUCK_W13 = 13'(DUCK_W);
  localparam logic [12:0] DUCK_H13 = 13'(DUCK_H);

  logic signed [3:0] vx;
  logic signed [3:0] vy;
  logic [FC_W-1:0]   frame_cnt;

  // Returns {bounced, new_pos}; overshoot clamps to the limit and flags a velocity flip.
  function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic signed [3:0] vel,
                                            input int lo, input int hi);
    logic signed [13:0] np;
    np = $signed({2'b00, pos}) + $signed({{10{vel[3]}}, vel});
    if (np < lo) return {1'b1, 12'(lo)};
    if (np > hi) return {1'b1, 12'(hi)};
    return {1'b0, np[11:0]};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic              shot_edge;
  logic              shot;
  logic              in_box;
  logic [12:0]       x_step;
  logic [12:0]       y_step;
  logic [12:0]       fall_sum;
  logic [11:0]       spawn_x;
  logic [2:0]        vx_mag;
  logic [2:0]        vy_mag;
  logic signed [3:0] spawn_vx;
  logic signed [3:0] spawn_vy;
  logic              spawn_now;
  logic              last_round;
  logic              unused_random;

  edge_detect u_left_edge (
    .clk   (clk),
    .rst   (rst),
    .level (left_mouse),
    .rise  (shot_edge)
  );

  assign unused_random = ^random[15:14];

  assign spawn_x  = 12'(X_MIN) + {3'b000, random[8:0]};
  assign vx_mag   = 3'(VEL_BASE) + {1'b0, random[10:9]};
  assign vy_mag   = 3'(VEL_BASE) + {1'b0, random[13:12]};
  assign spawn_vx = random[11] ? -$signed({1'b0, vx_mag}) : $signed({1'b0, vx_mag});
  assign spawn_vy = -$signed({1'b0, vy_mag});

  // Hit box is the current (pre-move) position; a same-cycle frame update never shifts it.
  assign in_box = ({1'b0, mouse_xpos} >= {1'b0, duck_xpos}) &&
                  ({1'b0, mouse_xpos} <  {1'b0, duck_xpos} + DUCK_W13) &&
                  ({1'b0, mouse_ypos} >= {1'b0, duck_ypos}) &&
                  ({1'b0, mouse_ypos} <  {1'b0, duck_ypos} + DUCK_H13);
  assign shot   = shot_edge && (duck_state == FLY) && (shots_left != 2'd0);

  assign x_step   = step_axis(duck_xpos, vx, X_MIN, X_MAX - DUCK_W);
  assign y_step   = step_axis(duck_ypos, vy, Y_MIN, Y_SPAWN);
  assign fall_sum = {1'b0, duck_ypos} + 13'(FALL_STEP);

  assign last_round = (round_no == 4'(ROUNDS - 1));
  assign spawn_now  = (duck_state == IDLE) || ((duck_state == NEXT) && !last_round);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      duck_state    <= IDLE;
      duck_xpos     <= '0;
      duck_ypos     <= '0;
      vx            <= '0;
      vy            <= '0;
      frame_cnt     <= '0;
      hits          <= '0;
      shots_left    <= '0;
      round_no      <= '0;
      duck_visible  <= 1'b0;
      game_finished <= 1'b0;
    end else begin
      case (duck_state)
        IDLE:  duck_state <= SPAWN;
        SPAWN: duck_state <= FLY;
        FLY: begin
          if (shot && in_box) begin
            duck_state <= HIT;
            hits       <= sat_inc(hits);
            shots_left <= shots_left - 2'd1;
            frame_cnt  <= '0;
          end else begin
            if (shot) shots_left <= shots_left - 2'd1;
            if (frame_tick) begin
              if ((shots_left == 2'd0) || (frame_cnt == FC_W'(FLIGHT_FRAMES - 1))) begin
                duck_state <= ESCAPE;
              end else begin
                duck_xpos <= x_step[11:0];
                duck_ypos <= y_step[11:0];
                if (x_step[12]) vx <= -vx;
                if (y_step[12]) vy <= -vy;
                frame_cnt <= frame_cnt + FC_W'(1);
              end
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (frame_cnt == FC_W'(HIT_FRAMES - 1)) begin
              duck_state <= FALL;
              frame_cnt  <= '0;
            end else begin
              frame_cnt <= frame_cnt + FC_W'(1);
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (fall_sum >= 13'(Y_SPAWN)) begin
              duck_ypos    <= 12'(Y_SPAWN);
              duck_visible <= 1'b0;
              duck_state   <= NEXT;
            end else begin
              duck_ypos <= fall_sum[11:0];
            end
          end
        end
        ESCAPE: begin
          if (frame_tick) begin
            if (duck_ypos <= 12'(ESCAPE_STEP)) begin
              duck_ypos    <= '0;
              duck_visible <= 1'b0;
              duck_state   <= NEXT;
            end else begin
              duck_ypos <= duck_ypos - 12'(ESCAPE_STEP);
            end
          end
        end
        NEXT: begin
          if (last_round) begin
            duck_state    <= DONE;
            game_finished <= 1'b1;
          end else begin
            round_no   <= round_no + 4'd1;
            duck_state <= SPAWN;
          end
        end
        DONE:    duck_state <= DONE;
        default: duck_state <= IDLE;
      endcase
      if (spawn_now) begin
        duck_xpos    <= spawn_x;
        duck_ypos    <= 12'(Y_SPAWN);
        vx           <= spawn_vx;
        vy           <= spawn_vy;
        shots_left   <= SHOTS_INIT;
        frame_cnt    <= '0;
        duck_visible <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_duck_ctrl.sv
// Directed bench for duck_ctrl: spawn, flight, hit/fall, escape, bounce, reset and full game.
module tb_duck_ctrl;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        frame_tick = 1'b0;
  logic [15:0] random = 16'h0000;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic        left_mouse = 1'b0;
  logic [11:0] duck_xpos, duck_ypos;
  logic        duck_visible, game_finished;
  duck_state_t duck_state;
  logic [7:0]  hits;
  logic [1:0]  shots_left;
  logic [3:0]  round_no;

  int n_checks = 0;
  int n_fail = 0;

  duck_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick), .random(random),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos), .left_mouse(left_mouse),
    .duck_xpos(duck_xpos), .duck_ypos(duck_ypos), .duck_visible(duck_visible),
    .duck_state(duck_state), .hits(hits), .shots_left(shots_left), .round_no(round_no),
    .game_finished(game_finished)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic click();
    left_mouse = 1'b1;
    cyc(2);
    left_mouse = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1;
    cyc(2);
    n_checks++; if (duck_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected %0d", duck_state, IDLE); end
    n_checks++; if ({duck_xpos, duck_ypos} !== 24'd0) begin n_fail++; $display("FAIL reset_pos: got %0d,%0d expected 0,0", duck_xpos, duck_ypos); end
    n_checks++; if ({duck_visible, game_finished, shots_left, hits, round_no} !== 16'd0) begin n_fail++; $display("FAIL reset_ctrl: vis %0d fin %0d shots %0d hits %0d round %0d expected all 0", duck_visible, game_finished, shots_left, hits, round_no); end
    enable = 1'b0;
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic test_spawn_fly();
    random = 16'h0000; enable = 1'b1;
    cyc(1);
    n_checks++; if (duck_state !== SPAWN) begin n_fail++; $display("FAIL spawn_state: got %0d expected %0d", duck_state, SPAWN); end
    n_checks++; if (duck_xpos !== 12'd64 || duck_ypos !== 12'd420) begin n_fail++; $display("FAIL spawn_pos: got %0d,%0d expected 64,420", duck_xpos, duck_ypos); end
    n_checks++; if (shots_left !== 2'd3 || duck_visible !== 1'b1) begin n_fail++; $display("FAIL spawn_shots_vis: got %0d,%0d expected 3,1", shots_left, duck_visible); end
    cyc(1);
    n_checks++; if (duck_state !== FLY) begin n_fail++; $display("FAIL fly_state: got %0d expected %0d", duck_state, FLY); end
    tick(10);
    n_checks++; if (duck_xpos !== 12'd74 || duck_ypos !== 12'd410) begin n_fail++; $display("FAIL fly_10_ticks: got %0d,%0d expected 74,410", duck_xpos, duck_ypos); end
  endtask

  task automatic test_hit_fall();
    mouse_xpos = 12'd100; mouse_ypos = 12'd430;
    left_mouse = 1'b1;
    cyc(1);
    n_checks++; if (duck_state !== FLY) begin n_fail++; $display("FAIL hit_latency: got %0d expected %0d", duck_state, FLY); end
    cyc(1);
    left_mouse = 1'b0;
    n_checks++; if (duck_state !== HIT) begin n_fail++; $display("FAIL hit_state: got %0d expected %0d", duck_state, HIT); end
    n_checks++; if (hits !== 8'd1 || shots_left !== 2'd2) begin n_fail++; $display("FAIL hit_counts: got hits %0d shots %0d expected 1,2", hits, shots_left); end
    tick(14);
    n_checks++; if (duck_state !== HIT || duck_ypos !== 12'd410) begin n_fail++; $display("FAIL hit_hold: got state %0d y %0d expected %0d,410", duck_state, duck_ypos, HIT); end
    tick(1);
    n_checks++; if (duck_state !== FALL) begin n_fail++; $display("FAIL hit_to_fall: got %0d expected %0d", duck_state, FALL); end
    tick(2);
    n_checks++; if (duck_ypos !== 12'd418 || duck_state !== FALL) begin n_fail++; $display("FAIL fall_step: got y %0d state %0d expected 418,%0d", duck_ypos, duck_state, FALL); end
    frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
    n_checks++; if (duck_ypos !== 12'd420 || duck_state !== NEXT || duck_visible !== 1'b0) begin n_fail++; $display("FAIL fall_land: got y %0d state %0d vis %0d expected 420,%0d,0", duck_ypos, duck_state, duck_visible, NEXT); end
    cyc(1);
    n_checks++; if (duck_state !== SPAWN || round_no !== 4'd1 || duck_visible !== 1'b1) begin n_fail++; $display("FAIL next_round: got state %0d round %0d vis %0d expected %0d,1,1", duck_state, round_no, duck_visible, SPAWN); end
  endtask

  task automatic test_miss_escape();
    int n;
    mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    cyc(1);
    click();
    n_checks++; if (shots_left !== 2'd2) begin n_fail++; $display("FAIL miss_shot1: got %0d expected 2", shots_left); end
    click();
    click();
    n_checks++; if (shots_left !== 2'd0 || hits !== 8'd1 || duck_state !== FLY) begin n_fail++; $display("FAIL miss_shot3: got shots %0d hits %0d state %0d expected 0,1,%0d", shots_left, hits, duck_state, FLY); end
    click();
    n_checks++; if (shots_left !== 2'd0) begin n_fail++; $display("FAIL no_shots_left: got %0d expected 0", shots_left); end
    tick(1);
    n_checks++; if (duck_state !== ESCAPE || duck_ypos !== 12'd420) begin n_fail++; $display("FAIL escape_entry: got state %0d y %0d expected %0d,420", duck_state, duck_ypos, ESCAPE); end
    tick(1);
    n_checks++; if (duck_ypos !== 12'd416 || duck_visible !== 1'b1) begin n_fail++; $display("FAIL escape_step: got y %0d vis %0d expected 416,1", duck_ypos, duck_visible); end
    n = 0;
    while (duck_ypos !== 12'd0 && n < 200) begin
      frame_tick = 1'b1; cyc(1); frame_tick = 1'b0;
      n++;
      if (duck_ypos !== 12'd0) cyc(1);
    end
    n_checks++; if (n != 104) begin n_fail++; $display("FAIL escape_ticks: got %0d expected 104", n); end
    n_checks++; if (duck_visible !== 1'b0 || duck_state !== NEXT) begin n_fail++; $display("FAIL escape_top: got vis %0d state %0d expected 0,%0d", duck_visible, duck_state, NEXT); end
    cyc(1);
    n_checks++; if (round_no !== 4'd2 || duck_state !== SPAWN) begin n_fail++; $display("FAIL escape_round: got round %0d state %0d expected 2,%0d", round_no, duck_state, SPAWN); end
  endtask

  task automatic test_bounce();
    enable = 1'b0;
    cyc(1);
    n_checks++; if (duck_state !== IDLE || round_no !== 4'd0 || hits !== 8'd0) begin n_fail++; $display("FAIL disable_idle: got state %0d round %0d hits %0d expected %0d,0,0", duck_state, round_no, hits, IDLE); end
    random = 16'h07FF; enable = 1'b1;
    cyc(1);
    n_checks++; if (duck_xpos !== 12'd575 || duck_ypos !== 12'd420) begin n_fail++; $display("FAIL bounce_spawn: got %0d,%0d expected 575,420", duck_xpos, duck_ypos); end
    cyc(1);
    tick(24);
    n_checks++; if (duck_xpos !== 12'd671 || duck_ypos !== 12'd396) begin n_fail++; $display("FAIL bounce_pre: got %0d,%0d expected 671,396", duck_xpos, duck_ypos); end
    tick(1);
    n_checks++; if (duck_xpos !== 12'd672) begin n_fail++; $display("FAIL bounce_clamp: got %0d expected 672", duck_xpos); end
    tick(1);
    n_checks++; if (duck_xpos !== 12'd668 || duck_ypos !== 12'd394) begin n_fail++; $display("FAIL bounce_reverse: got %0d,%0d expected 668,394", duck_xpos, duck_ypos); end
    // Mouse inside the current box only; the moved box would exclude x=731.
    mouse_xpos = 12'd731; mouse_ypos = 12'd394;
    left_mouse = 1'b1;
    cyc(1);
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0; left_mouse = 1'b0;
    n_checks++; if (duck_state !== HIT || hits !== 8'd1) begin n_fail++; $display("FAIL preupdate_hit: got state %0d hits %0d expected %0d,1", duck_state, hits, HIT); end
  endtask

  task automatic test_reset_mid_fly();
    random = 16'h0000;
    enable = 1'b0; cyc(1);
    enable = 1'b1; cyc(2);
    tick(3);
    n_checks++; if (duck_state !== FLY || duck_xpos !== 12'd67) begin n_fail++; $display("FAIL prereset_fly: got state %0d x %0d expected %0d,67", duck_state, duck_xpos, FLY); end
    rst = 1'b1;
    cyc(1);
    n_checks++; if (duck_state !== IDLE || {duck_xpos, duck_ypos} !== 24'd0 || {duck_visible, game_finished, shots_left, hits, round_no} !== 16'd0) begin n_fail++; $display("FAIL reset_mid_fly: state %0d x %0d y %0d vis %0d shots %0d expected IDLE and zeros", duck_state, duck_xpos, duck_ypos, duck_visible, shots_left); end
    rst = 1'b0; enable = 1'b0;
    cyc(1);
  endtask

  task automatic test_ten_rounds();
    int n;
    random = 16'h0000; mouse_xpos = 12'd0; mouse_ypos = 12'd0;
    enable = 1'b1; frame_tick = 1'b1;
    n = 0;
    while (game_finished !== 1'b1 && n < 20000) begin cyc(1); n++; end
    frame_tick = 1'b0;
    n_checks++; if (game_finished !== 1'b1) begin n_fail++; $display("FAIL game_timeout: finished %0d after %0d cycles expected 1", game_finished, n); end
    n_checks++; if (duck_state !== DONE || round_no !== 4'd9 || duck_visible !== 1'b0) begin n_fail++; $display("FAIL game_done: got state %0d round %0d vis %0d expected %0d,9,0", duck_state, round_no, duck_visible, DONE); end
    cyc(5);
    n_checks++; if (game_finished !== 1'b1 || duck_state !== DONE) begin n_fail++; $display("FAIL done_hold: got fin %0d state %0d expected 1,%0d", game_finished, duck_state, DONE); end
    enable = 1'b0;
    cyc(1);
    n_checks++; if (duck_state !== IDLE || game_finished !== 1'b0) begin n_fail++; $display("FAIL done_exit: got state %0d fin %0d expected %0d,0", duck_state, game_finished, IDLE); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_spawn_fly();
    test_hit_fall();
    test_miss_escape();
    test_bounce();
    test_reset_mid_fly();
    test_ten_rounds();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/duck_ctrl.md
DUCK_CTRL -- requirements
Module: duck_ctrl

Interface
REQ-001 SHALL have parameter X_MIN, default 64, meaning leftmost duck x (pixels).
REQ-002 SHALL have parameter X_MAX, default 736, meaning rightmost duck x plus DUCK_W.
REQ-003 SHALL have parameter Y_MIN, default 32, meaning top flight limit.
REQ-004 SHALL have parameter Y_SPAWN, default 420, meaning spawn and bottom y.
REQ-005 SHALL have parameters DUCK_W and DUCK_H, default 64 each, meaning hitbox size.
REQ-006 SHALL have parameters ROUNDS=10, FLIGHT_FRAMES=300 and HIT_FRAMES=15.
REQ-007 SHALL have port clk, input, 1 bit: the single system clock.
REQ-008 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port enable, input, 1 bit: game_enable from game_control_fsm.
REQ-010 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-011 SHALL have port random, input, 16 bits: LFSR output.
REQ-012 SHALL have ports mouse_xpos and mouse_ypos, input, 12 bits each.
REQ-013 SHALL have port left_mouse, input, 1 bit: level button.
REQ-014 SHALL have ports duck_xpos and duck_ypos, output, 12 bits each: duck top-left position.
REQ-015 SHALL have port duck_visible, output, 1 bit.
REQ-016 SHALL have port duck_state, output, duck_state_t: current FSM state, used for sprite selection.
REQ-017 SHALL have output ports hits (8b), shots_left (2b) and round_no (4b).
REQ-018 SHALL have port game_finished, output, 1 bit: consumed by game_control_fsm.

Function
REQ-019 FSM states SHALL be IDLE, SPAWN, FLY, HIT, FALL, ESCAPE, NEXT, DONE.
REQ-020 IDLE->SPAWN SHALL occur on the first cycle enable=1; enable=0 in any state SHALL force IDLE with reset values next cycle.
REQ-021 SPAWN (1 cycle) SHALL load x=X_MIN+random[8:0] and y=Y_SPAWN, with unsigned 12-bit arithmetic.
REQ-022 SPAWN SHALL set |vx|=1+random[10:9], sign random[11] (1=left), |vy|=1+random[13:12] upward, shots_left=3, frame counter=0.
REQ-023 FLY SHALL update x+=vx and y+=vy only on frame_tick.
REQ-024 On overshoot of [X_MIN, X_MAX-DUCK_W] or [Y_MIN, Y_SPAWN], position SHALL clamp to the limit and that velocity sign SHALL invert in the same update.
REQ-025 Shot detection SHALL use a rising edge of left_mouse, registered one cycle, valid only in FLY with shots_left>0; each shot decrements shots_left.
REQ-026 Hit SHALL require x<=mouse_xpos<x+DUCK_W and y<=mouse_ypos<y+DUCK_H, using the position before any same-cycle frame_tick update.
REQ-027 Hit SHALL cause FLY->HIT next cycle and hits+=1, saturating at 255.
REQ-028 HIT SHALL hold the position for HIT_FRAMES frame_ticks, then go to FALL.
REQ-029 FALL SHALL apply y+=4 per frame_tick; at y>=Y_SPAWN it SHALL set y=Y_SPAWN, then go to NEXT.
REQ-030 FLY->ESCAPE SHALL occur when the frame counter reaches FLIGHT_FRAMES, or on the first frame_tick after shots_left becomes 0 without a hit.
REQ-031 ESCAPE SHALL apply y-=4 per frame_tick, saturating at 0; y==0 SHALL cause duck_visible=0, then NEXT.
REQ-032 NEXT (1 cycle) SHALL go to DONE if round_no==ROUNDS-1, else round_no+=1 and SPAWN.
REQ-033 DONE SHALL hold game_finished=1 and duck_visible=0 until enable=0.
REQ-034 duck_visible SHALL be 1 in SPAWN, FLY, HIT and FALL, and in ESCAPE until y==0.

Reset
REQ-035 On rst=1 at a clk edge, state SHALL be IDLE, all position/velocity/counters 0, shots_left=0, and duck_visible=0 and game_finished=0.
REQ-036 Reset SHALL take priority over enable and every other input, including mid-flight.

Structure
REQ-037 duck_state_t and the velocity/fall/escape step constants SHALL live in a shared game_pkg.
REQ-038 Rising-edge detection SHALL be a sub-module edge_detect, reusable for right_mouse.
REQ-039 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Verification
REQ-040 random=16'h0000 at SPAWN -> x=64, y=420, vx=+1, vy=-1; after 10 frame_ticks x=74, y=410.
REQ-041 Click inside the box during FLY -> HIT one cycle after the registered edge, hits=1, shots_left=2; after 15 ticks, FALL.
REQ-042 Three clicks outside the box -> shots_left=0, ESCAPE on the next frame_tick, duck_visible=0 at y==0, round_no increments.
REQ-043 Duck placed at x=671 with vx=+4 -> x=672 and vx=-4 after one tick; click and frame_tick on the same cycle uses the pre-update box.
REQ-044 Ten rounds complete -> game_finished=1 held; enable=0 -> IDLE; rst mid-FLY -> all outputs at reset values next cycle.
